// File: rtl/spi_host_master_if.sv
// spi_host_master_if: local start/busy/done request bundle for spi_host_master.
interface spi_host_master_if;
    logic       start;
    logic       rd_not_wr;
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    modport master (
        output start, rd_not_wr, cmd, addr, wr_data,
        input  busy, done, rd_data, rd_valid
    );
    modport slave (
        input  start, rd_not_wr, cmd, addr, wr_data,
        output busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/spi_host_master.sv
// spi_host_master: SPI mode-0 master sending fixed cmd/addr/data frames.
// Build option SPI_HOST_LSB_FIRST_EN: each byte is sent and captured LSB first.
module spi_host_master #(
    parameter int CLK_DIV = 3,
    parameter int CS_CYC  = 4
) (
    input  logic             clk,
    input  logic             async_reset,
    spi_host_master_if.slave host,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_csn
);
    localparam int MAXC = (CS_CYC > CLK_DIV) ? CS_CYC : CLK_DIV;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] CS_LAST = CW'(CS_CYC - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    bit_cnt, bit_nxt;
    logic [23:0]   sr, sr_nxt;
    logic [7:0]    cap, cap_nxt, cap_shift;
    logic          rd_flag, rd_flag_nxt;
    logic          busy_r, busy_nxt;
    logic          done_r, done_nxt;
    logic          valid_r, valid_nxt;
    logic [7:0]    rd_data_r, rd_data_nxt;
    logic          sck_nxt, mosi_nxt, csn_nxt;

    function automatic logic [7:0] order(input logic [7:0] b);
        logic [7:0] r;
`ifdef SPI_HOST_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
        r = b;
`endif
        return r;
    endfunction

`ifdef SPI_HOST_LSB_FIRST_EN
    assign cap_shift = {spi_miso, cap[7:1]};
`else
    assign cap_shift = {cap[6:0], spi_miso};
`endif

    assign host.busy     = busy_r;
    assign host.done     = done_r;
    assign host.rd_valid = valid_r;
    assign host.rd_data  = rd_data_r;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_nxt     = bit_cnt;
        sr_nxt      = sr;
        cap_nxt     = cap;
        rd_flag_nxt = rd_flag;
        busy_nxt    = busy_r;
        done_nxt    = 1'b0;
        valid_nxt   = 1'b0;
        rd_data_nxt = rd_data_r;
        sck_nxt     = spi_clk;
        mosi_nxt    = spi_mosi;
        csn_nxt     = spi_csn;
        case (state)
            IDLE: begin
                if (host.start) begin
                    sr_nxt      = {order(host.cmd), order(host.addr),
                                   host.rd_not_wr ? 8'h00 : order(host.wr_data)};
                    rd_flag_nxt = host.rd_not_wr;
                    busy_nxt    = 1'b1;
                    csn_nxt     = 1'b0;
                    mosi_nxt    = sr_nxt[23];
                    cnt_nxt     = '0;
                    bit_nxt     = '0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                if (cnt == CS_LAST) begin
                    cnt_nxt   = '0;
                    sck_nxt   = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (spi_clk && cnt == '0) cap_nxt = cap_shift;
                if (cnt != DIV_LAST) begin
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    cnt_nxt = '0;
                    if (spi_clk) begin
                        sck_nxt  = 1'b0;
                        sr_nxt   = {sr[22:0], 1'b0};
                        mosi_nxt = sr[22];
                    end else begin
                        bit_nxt = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) state_nxt = HOLD;
                        else sck_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt == CS_LAST) begin
                    cnt_nxt   = '0;
                    csn_nxt   = 1'b1;
                    mosi_nxt  = 1'b0;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == CS_LAST) begin
                    cnt_nxt     = '0;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    valid_nxt   = rd_flag;
                    rd_data_nxt = cap;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers, cleared immediately by async_reset.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            cap       <= '0;
            rd_flag   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            valid_r   <= 1'b0;
            rd_data_r <= '0;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_csn   <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_cnt   <= bit_nxt;
            sr        <= sr_nxt;
            cap       <= cap_nxt;
            rd_flag   <= rd_flag_nxt;
            busy_r    <= busy_nxt;
            done_r    <= done_nxt;
            valid_r   <= valid_nxt;
            rd_data_r <= rd_data_nxt;
            spi_clk   <= sck_nxt;
            spi_mosi  <= mosi_nxt;
            spi_csn   <= csn_nxt;
        end
    end
endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: directed self-checking bench with an SPI slave model.
module tb_spi_host_master;
`ifdef SPI_HOST_LSB_FIRST_EN
    localparam int CLK_DIV = 1;
    localparam int CS_CYC  = 1;
`else
    localparam int CLK_DIV = 3;
    localparam int CS_CYC  = 4;
`endif
    localparam int T = 3 * CS_CYC + 48 * CLK_DIV;

    logic clk = 1'b0;
    logic async_reset = 1'b1;
    logic spi_clk, spi_mosi, spi_csn;
    logic spi_miso = 1'b0;

    spi_host_master_if h();

    spi_host_master #(.CLK_DIV(CLK_DIV), .CS_CYC(CS_CYC)) dut (
        .clk(clk),
        .async_reset(async_reset),
        .host(h),
        .spi_clk(spi_clk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_csn(spi_csn)
    );

    int checks = 0, errors = 0;
    int busy_cyc = 0, done_cnt = 0, rv_cnt = 0, csn_low = 0, frames = 0;
    int rises = 0, hi_run = 0, last_gap = 0, idx = 0;
    logic [23:0] mosi_bits = '0, slave_frame = '0;
    logic [7:0] got_data;
    logic got_valid, seen;

    always #5 clk = ~clk;

    function automatic logic [7:0] ord8(input logic [7:0] b);
        logic [7:0] r;
`ifdef SPI_HOST_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
        r = b;
`endif
        return r;
    endfunction

    function automatic logic [23:0] exp_frame(input logic [7:0] c, a, d);
        return {ord8(c), ord8(a), ord8(d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic clear();
        busy_cyc = 0; done_cnt = 0; rv_cnt = 0; csn_low = 0; frames = 0;
    endtask

    task automatic set_slave(input logic [7:0] b);
        slave_frame = {16'h0000, ord8(b)};
    endtask

    task automatic start_frame(input logic rd, input logic [7:0] c, a, d);
        @(negedge clk);
        h.start = 1'b1; h.rd_not_wr = rd; h.cmd = c; h.addr = a; h.wr_data = d;
        @(negedge clk);
        h.start = 1'b0;
    endtask

    task automatic wait_done();
        seen = 1'b0;
        for (int i = 0; i < 4 * T + 50 && !seen; i++) begin
            @(negedge clk);
            if (h.done) begin
                seen = 1'b1; got_data = h.rd_data; got_valid = h.rd_valid;
            end
        end
        if (!seen) chk("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Per-cycle activity counters sampled mid-cycle.
    always @(negedge clk) begin
        if (h.busy) busy_cyc++;
        if (h.done) done_cnt++;
        if (h.rd_valid) rv_cnt++;
        if (spi_csn === 1'b0) csn_low++;
        if (spi_csn === 1'b1) hi_run++;
        else begin
            if (hi_run != 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    // Slave model: frame start, MOSI capture on SCK rise, MISO update on SCK fall.
    always @(negedge spi_csn) begin
        frames++; rises = 0; mosi_bits = '0; idx = 23; spi_miso = slave_frame[23];
    end
    always @(posedge spi_clk) begin
        rises++; mosi_bits = {mosi_bits[22:0], spi_mosi};
    end
    always @(negedge spi_clk) begin
        if (idx > 0) begin idx--; spi_miso = slave_frame[idx]; end
    end

    initial begin
        h.start = 1'b0; h.rd_not_wr = 1'b0; h.cmd = '0; h.addr = '0; h.wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(h.busy), 32'd0);
        chk("rst_done", 32'(h.done), 32'd0);
        chk("rst_rd_valid", 32'(h.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(h.rd_data), 32'h00);
        chk("rst_spi_clk", 32'(spi_clk), 32'd0);
        chk("rst_spi_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_spi_csn", 32'(spi_csn), 32'd1);
        @(negedge clk); async_reset = 1'b0;
        repeat (2) @(negedge clk);

        set_slave(8'h3C); clear();
        start_frame(1'b0, 8'h02, 8'h10, 8'hA5);
        wait_done();
        chk("wr_rd_valid_at_done", 32'(got_valid), 32'd0);
        chk("wr_rd_data", 32'(got_data), 32'h3C);
        wait_cycles(3);
        chk("wr_mosi", 32'(mosi_bits), 32'(exp_frame(8'h02, 8'h10, 8'hA5)));
        chk("wr_rises", 32'(rises), 32'd24);
        chk("wr_busy_cycles", 32'(busy_cyc), 32'(T));
        chk("wr_done_pulses", 32'(done_cnt), 32'd1);
        chk("wr_rd_valid_pulses", 32'(rv_cnt), 32'd0);
        chk("wr_csn_low", 32'(csn_low), 32'(2 * CS_CYC + 48 * CLK_DIV));

        set_slave(8'h5A); clear();
        start_frame(1'b1, 8'h03, 8'h20, 8'hFF);
        wait_done();
        chk("rd_rd_data", 32'(got_data), 32'h5A);
        chk("rd_rd_valid_at_done", 32'(got_valid), 32'd1);
        wait_cycles(3);
        chk("rd_mosi", 32'(mosi_bits), 32'(exp_frame(8'h03, 8'h20, 8'h00)));
        chk("rd_busy_cycles", 32'(busy_cyc), 32'(T));
        chk("rd_rd_valid_pulses", 32'(rv_cnt), 32'd1);

        set_slave(8'h77); clear();
        start_frame(1'b0, 8'h04, 8'h30, 8'h11);
        for (int i = 0; i < T / 2; i++) begin
            @(negedge clk);
            h.start = ~h.start; h.cmd = h.cmd + 8'h11; h.addr = ~h.addr; h.wr_data = h.wr_data ^ 8'h5F;
        end
        h.start = 1'b0;
        wait_done();
        wait_cycles(T);
        chk("ign_frames", 32'(frames), 32'd1);
        chk("ign_mosi", 32'(mosi_bits), 32'(exp_frame(8'h04, 8'h30, 8'h11)));
        chk("ign_done_pulses", 32'(done_cnt), 32'd1);
        chk("ign_rd_data", 32'(got_data), 32'h77);

        set_slave(8'h00); clear();
        start_frame(1'b0, 8'h09, 8'h09, 8'h09);
        seen = 1'b0;
        for (int i = 0; i < 4 * T && !seen; i++) begin
            @(negedge clk);
            if (rises == 10) seen = 1'b1;
        end
        chk("rst_mid_reach_bit10", 32'(seen), 32'd1);
        #1 async_reset = 1'b1;
        #1;
        chk("rst_mid_csn", 32'(spi_csn), 32'd1);
        chk("rst_mid_spi_clk", 32'(spi_clk), 32'd0);
        chk("rst_mid_busy", 32'(h.busy), 32'd0);
        chk("rst_mid_rd_data", 32'(h.rd_data), 32'h00);
        @(negedge clk); async_reset = 1'b0;
        repeat (2) @(negedge clk);
        clear();
        start_frame(1'b0, 8'h01, 8'h02, 8'h03);
        wait_done();
        wait_cycles(3);
        chk("post_rst_mosi", 32'(mosi_bits), 32'(exp_frame(8'h01, 8'h02, 8'h03)));
        chk("post_rst_busy_cycles", 32'(busy_cyc), 32'(T));
        chk("post_rst_done_pulses", 32'(done_cnt), 32'd1);

        clear();
        @(negedge clk);
        h.start = 1'b1; h.rd_not_wr = 1'b0; h.cmd = 8'h05; h.addr = 8'h06; h.wr_data = 8'h07;
        wait_done();
        @(negedge clk);
        chk("b2b_restart_busy", 32'(h.busy), 32'd1);
        h.start = 1'b0;
        wait_cycles(1);
        chk("b2b_csn_gap_ok", 32'(last_gap >= CS_CYC), 32'd1);
        wait_done();
        wait_cycles(3);
        chk("b2b_frames", 32'(frames), 32'd2);
        chk("b2b_busy_cycles", 32'(busy_cyc), 32'(2 * T));
        chk("b2b_mosi", 32'(mosi_bits), 32'(exp_frame(8'h05, 8'h06, 8'h07)));

        set_slave(8'h5A); clear();
        start_frame(1'b0, 8'h80, 8'h01, 8'hC3);
        wait_done();
        chk("ord_rd_data", 32'(got_data), 32'h5A);
        wait_cycles(3);
        chk("ord_mosi", 32'(mosi_bits), 32'(exp_frame(8'h80, 8'h01, 8'hC3)));
        chk("ord_busy_cycles", 32'(busy_cyc), 32'(T));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
